hfrv_trace_capture: RTL and testbench

Synthesizable retirement-trace buffer sitting directly upstream of the verification monitor. It captures one snapshot per retired instruction (PC, instruction word, data address, write data, byte-write strobes) from the core side of `dut_top`, tags each snapshot with a sequence number, and queues it in a FIFO. The monitor drains the FIFO through a valid/ready port. Overflow drops are counted, never silent, so the monitor and its callbacks (opcode/instruction coverage, addi assertion, debug dumps) can detect gaps.

---
 rtl/hfrv_trace_capture.sv | 143 ++++++++++++++
 tb/tb_hfrv_trace_capture.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hfrv_trace_capture.sv
// ----------------------------------------------------------------------------
// hfrv_trace_capture
//
// Retirement-trace buffer. Captures one snapshot per retired instruction,
// tags it with a sequence number and queues it in a first-word-fall-through
// FIFO that the verification monitor drains through a valid/ready port.
// Snapshots that arrive while the FIFO is full (and nothing is popped in the
// same cycle) are dropped and counted in a saturating drop counter. Because
// dropped snapshots still consume a sequence number, the consumer can see
// every gap.
//
// Ports:
//   clk, reset            core clock, asynchronous active-high reset
//   en_i                  capture enable (retire strobes ignored when low)
//   ret_valid_i           one instruction retired this cycle
//   ret_pc_i, ret_instr_i PC and instruction word of the retired instruction
//   mem_addr_i/wdata_i    data address / store data
//   mem_we_i              byte-write strobes (0 for a non-store)
//   out_valid_o           head entry valid
//   out_ready_i           monitor accepts the head entry
//   out_*_o               head entry fields (zero while empty)
//   out_seq_o             sequence number of the head entry
//   level_o               current occupancy
//   drop_cnt_o            saturating count of dropped snapshots
// ----------------------------------------------------------------------------
module hfrv_trace_capture #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SEQ_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en_i,
    input  logic                       ret_valid_i,
    input  logic [31:0]                ret_pc_i,
    input  logic [31:0]                ret_instr_i,
    input  logic [31:0]                mem_addr_i,
    input  logic [31:0]                mem_wdata_i,
    input  logic [3:0]                 mem_we_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_pc_o,
    output logic [31:0]                out_instr_o,
    output logic [31:0]                out_addr_o,
    output logic [31:0]                out_wdata_o,
    output logic [3:0]                 out_we_o,
    output logic [SEQ_W-1:0]           out_seq_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [SEQ_W-1:0]           drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [3:0]       we;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           head;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] drop_q, drop_d;

    logic push, pop, full, store, drop;

    always_comb begin
        push  = en_i & ret_valid_i;
        pop   = (level_q != '0) & out_ready_i;
        full  = (level_q == LW'(DEPTH));
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        store = push & (~full | pop);
        drop  = push & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        seq_d    = seq_q;
        drop_d   = drop_q;

        if (store) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);

        case ({store, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Dropped snapshots still burn a sequence number so gaps are visible.
        if (push) seq_d = seq_q + SEQ_W'(1);
        if (drop && (drop_q != '1)) drop_d = drop_q + SEQ_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    // Payload storage needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q].pc    <= ret_pc_i;
            mem_q[wr_ptr_q].instr <= ret_instr_i;
            mem_q[wr_ptr_q].addr  <= mem_addr_i;
            mem_q[wr_ptr_q].wdata <= mem_wdata_i;
            mem_q[wr_ptr_q].we    <= mem_we_i;
            mem_q[wr_ptr_q].seq   <= seq_q;
        end
    end

    always_comb begin
        head        = mem_q[rd_ptr_q];
        out_valid_o = (level_q != '0);
        out_pc_o    = out_valid_o ? head.pc    : '0;
        out_instr_o = out_valid_o ? head.instr : '0;
        out_addr_o  = out_valid_o ? head.addr  : '0;
        out_wdata_o = out_valid_o ? head.wdata : '0;
        out_we_o    = out_valid_o ? head.we    : '0;
        out_seq_o   = out_valid_o ? head.seq   : '0;
        level_o     = level_q;
        drop_cnt_o  = drop_q;
    end

endmodule

// File: tb/tb_hfrv_trace_capture.sv
// ----------------------------------------------------------------------------
// tb_hfrv_trace_capture
//
// Scoreboard bench. A reference model (a queue of expected snapshots plus
// occupancy, sequence and drop counters) pushes expectations at each rising
// edge; a monitor on the falling edge compares the DUT head, occupancy and
// drop count against the scoreboard and retires entries on handshakes.
// Directed sequences add explicit constant checks on top.
// ----------------------------------------------------------------------------
module tb_hfrv_trace_capture;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SEQ_W = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [15:0] seq;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_i = 1'b0;
    logic        ret_valid_i = 1'b0;
    logic [31:0] ret_pc_i = '0;
    logic [31:0] ret_instr_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [3:0]  mem_we_i = '0;
    logic        out_ready_i = 1'b0;
    logic        out_valid_o;
    logic [31:0] out_pc_o, out_instr_o, out_addr_o, out_wdata_o;
    logic [3:0]  out_we_o;
    logic [15:0] out_seq_o;
    logic [4:0]  level_o;
    logic [15:0] drop_cnt_o;

    int n_checks = 0;
    int n_pass = 0;

    ent_t        exp_q[$];
    int          lvl_m = 0;
    logic [15:0] seq_m = '0;
    logic [15:0] drops_m = '0;

    hfrv_trace_capture #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .ret_valid_i (ret_valid_i),
        .ret_pc_i    (ret_pc_i),
        .ret_instr_i (ret_instr_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_we_i    (mem_we_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pc_o    (out_pc_o),
        .out_instr_o (out_instr_o),
        .out_addr_o  (out_addr_o),
        .out_wdata_o (out_wdata_o),
        .out_we_o    (out_we_o),
        .out_seq_o   (out_seq_o),
        .level_o     (level_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a FIFO of snapshots with a depth limit and drop rule.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                exp_q.delete();
                lvl_m   = 0;
                seq_m   = '0;
                drops_m = '0;
            end else begin
                bit pop_m;
                pop_m = (lvl_m != 0) && out_ready_i;
                if (en_i && ret_valid_i) begin
                    if (lvl_m < DEPTH || pop_m) begin
                        ent_t e;
                        e.pc = ret_pc_i; e.instr = ret_instr_i; e.addr = mem_addr_i;
                        e.wdata = mem_wdata_i; e.we = mem_we_i; e.seq = seq_m;
                        exp_q.push_back(e);
                        lvl_m++;
                    end else if (drops_m != 16'hFFFF) begin
                        drops_m++;
                    end
                    seq_m++;
                end
                if (pop_m) lvl_m--;
            end
        end
    end

    // Monitor: compares the presented head with the scoreboard front.
    initial begin
        forever begin
            @(negedge clk);
            check("valid", {63'd0, out_valid_o}, {63'd0, exp_q.size() != 0});
            check("level", {59'd0, level_o}, 64'(exp_q.size()));
            check("drop_cnt", {48'd0, drop_cnt_o}, {48'd0, drops_m});
            if (exp_q.size() != 0) begin
                check("head_pc", {32'd0, out_pc_o}, {32'd0, exp_q[0].pc});
                check("head_instr", {32'd0, out_instr_o}, {32'd0, exp_q[0].instr});
                check("head_addr", {32'd0, out_addr_o}, {32'd0, exp_q[0].addr});
                check("head_wdata", {32'd0, out_wdata_o}, {32'd0, exp_q[0].wdata});
                check("head_we", {60'd0, out_we_o}, {60'd0, exp_q[0].we});
                check("head_seq", {48'd0, out_seq_o}, {48'd0, exp_q[0].seq});
                if (out_ready_i) void'(exp_q.pop_front());
            end else begin
                check("empty_data_zero",
                      {out_pc_o | out_instr_o | out_addr_o | out_wdata_o,
                       12'd0, out_we_o, out_seq_o}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        ret_pc_i    = $urandom;
        ret_instr_i = $urandom;
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
        mem_we_i    = 4'($urandom_range(0, 15));
    endtask

    task automatic push(input logic [31:0] pc);
        rand_fields();
        ret_pc_i    = pc;
        en_i        = 1'b1;
        ret_valid_i = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en_i = 1'b0; ret_valid_i = 1'b0; out_ready_i = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_valid", {63'd0, out_valid_o}, 64'd0);
        check("rst_level", {59'd0, level_o}, 64'd0);
        check("rst_drop", {48'd0, drop_cnt_o}, 64'd0);
        check("rst_pc", {32'd0, out_pc_o}, 64'd0);
        reset = 1'b0;

        // Three pushes, then drain in order
        out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(32'h100 + 32'(4 * k));
            tick();
        end
        ret_valid_i = 1'b0;
        check("t1_level", {59'd0, level_o}, 64'd3);
        check("t1_pc", {32'd0, out_pc_o}, 64'h100);
        check("t1_seq", {48'd0, out_seq_o}, 64'd0);
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k < 2) begin
                check("t1_pop_pc", {32'd0, out_pc_o}, 64'(32'h104 + 32'(4 * k)));
                check("t1_pop_seq", {48'd0, out_seq_o}, 64'(k + 1));
            end else begin
                check("t1_empty", {63'd0, out_valid_o}, 64'd0);
            end
        end

        // Overflow: 20 pushes into 16 entries
        do_reset();
        for (int k = 0; k < 20; k++) begin
            push($urandom);
            tick();
        end
        ret_valid_i = 1'b0;
        check("t2_level", {59'd0, level_o}, 64'd16);
        check("t2_drop", {48'd0, drop_cnt_o}, 64'd4);
        out_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("t2_drain_seq", {48'd0, out_seq_o}, 64'(k));
            tick();
        end
        check("t2_drained", {63'd0, out_valid_o}, 64'd0);
        out_ready_i = 1'b0;
        push($urandom);
        tick();
        ret_valid_i = 1'b0;
        check("t2_next_seq", {48'd0, out_seq_o}, 64'd20);

        // Full FIFO with simultaneous push and pop
        for (int k = 0; k < 15; k++) begin
            push($urandom);
            tick();
        end
        check("t3_full", {59'd0, level_o}, 64'd16);
        push($urandom);
        out_ready_i = 1'b1;
        tick();
        ret_valid_i = 1'b0;
        check("t3_level", {59'd0, level_o}, 64'd16);
        check("t3_drop", {48'd0, drop_cnt_o}, 64'd4);
        check("t3_head", {48'd0, out_seq_o}, 64'd21);
        for (int k = 0; k < 15; k++) tick();
        check("t3_tail_seq", {48'd0, out_seq_o}, 64'd36);
        tick();
        check("t3_drained", {63'd0, out_valid_o}, 64'd0);

        // Store snapshot held under back-pressure
        do_reset();
        push(32'h200);
        mem_we_i = 4'b0011; mem_addr_i = 32'h4000; mem_wdata_i = 32'hDEADBEEF;
        tick();
        ret_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t4_we", {60'd0, out_we_o}, 64'h3);
            check("t4_addr", {32'd0, out_addr_o}, 64'h4000);
            check("t4_wdata", {32'd0, out_wdata_o}, 64'hDEADBEEF);
            tick();
        end
        out_ready_i = 1'b1;
        tick();

        // Asynchronous reset mid-operation
        out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push($urandom);
            tick();
        end
        ret_valid_i = 1'b0;
        check("t5_level5", {59'd0, level_o}, 64'd5);
        #2 reset = 1'b1;
        #1;
        check("t5_async_valid", {63'd0, out_valid_o}, 64'd0);
        check("t5_async_level", {59'd0, level_o}, 64'd0);
        tick();
        reset = 1'b0;
        push($urandom);
        tick();
        ret_valid_i = 1'b0;
        check("t5_seq0", {48'd0, out_seq_o}, 64'd0);
        check("t5_level1", {59'd0, level_o}, 64'd1);
        out_ready_i = 1'b1;
        tick();

        // Streaming: 1000 cycles with no gaps, then run on past the seq wrap
        do_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i <= 65536; i++) begin
            push($urandom);
            tick();
            if (i < 1000 || i >= 65534) begin
                logic [15:0] s;
                s = 16'(i);
                check("stream_seq", {48'd0, out_seq_o}, {48'd0, s});
                check("stream_level", {59'd0, level_o}, 64'd1);
            end
        end
        ret_valid_i = 1'b0;
        tick();

        // Randomized traffic with varying back-pressure and enable
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int unsigned rdy_pct;
            rdy_pct = $urandom_range(10, 90);
            for (int c = 0; c < 500; c++) begin
                rand_fields();
                en_i        = ($urandom_range(0, 7) != 0);
                ret_valid_i = ($urandom_range(0, 99) < 70);
                out_ready_i = ($urandom_range(0, 99) < rdy_pct);
                tick();
            end
        end

        // Final drain
        en_i = 1'b0; ret_valid_i = 1'b0; out_ready_i = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) tick();
        check("final_empty", {63'd0, out_valid_o}, 64'd0);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
